// File: rtl/vx_gbar_collector_pkg.sv
// Shared widths and request/response payloads for the cluster global-barrier bus.
package vx_gbar_collector_pkg;

    localparam int GBAR_NUM_CORES    = 4;
    localparam int GBAR_NUM_BARRIERS = 8;
    localparam int NC_WIDTH = (GBAR_NUM_CORES > 1) ? $clog2(GBAR_NUM_CORES) : 1;
    localparam int NB_WIDTH = (GBAR_NUM_BARRIERS > 1) ? $clog2(GBAR_NUM_BARRIERS) : 1;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
        logic [NC_WIDTH-1:0] size_m1;
        logic [NC_WIDTH-1:0] core_id;
    } gbar_req_data_t;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
    } gbar_rsp_data_t;

endpackage

// File: rtl/vx_gbar_collector_arb.sv
// Round-robin arbiter: one-hot grant, priority restarts one past the last winner.
module vx_gbar_collector_arb #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     grant_o,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_index_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               idx;

    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        grant_index_o = '0;
        found         = 1'b0;
        idx           = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                grant_o[idx]  = 1'b1;
                grant_index_o = IDX_W'(idx);
            end
        end
        grant_valid_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid_o) begin
            ptr_d = (grant_index_o == IDX_W'(N - 1)) ? '0 : grant_index_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/vx_gbar_collector.sv
// Global-barrier collector: counts per-barrier core arrivals and broadcasts a
// one-cycle release pulse when the last participant arrives.
module vx_gbar_collector
    import vx_gbar_collector_pkg::*;
#(
    parameter int NUM_REQS     = GBAR_NUM_CORES,
    parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req_valid_i,
    input  gbar_req_data_t      req_data_i [NUM_REQS],
    output logic [NUM_REQS-1:0] req_ready_o,
    output logic [NUM_REQS-1:0] rsp_valid_o,
    output gbar_rsp_data_t      rsp_data_o [NUM_REQS],
    output logic                error,
    output logic                busy
);

    // Handshake: a request transfers on any cycle where req_valid_i[i] && req_ready_o[i];
    // ready is the arbiter grant, so a losing core holds valid and data until granted.
    logic [NUM_REQS-1:0] grant;
    logic                grant_valid;
    logic [NC_WIDTH-1:0] grant_idx;

    vx_gbar_collector_arb #(
        .N     (NUM_REQS),
        .IDX_W (NC_WIDTH)
    ) u_arb (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req_valid_i),
        .grant_o       (grant),
        .grant_valid_o (grant_valid),
        .grant_index_o (grant_idx)
    );

    assign req_ready_o = grant;

    gbar_req_data_t acc;
    assign acc = req_data_i[grant_idx];

    logic [NUM_REQS-1:0] mask_q [NUM_BARRIERS];
    logic [NUM_REQS-1:0] mask_d [NUM_BARRIERS];
    logic [NC_WIDTH-1:0] cnt_q  [NUM_BARRIERS];
    logic [NC_WIDTH-1:0] cnt_d  [NUM_BARRIERS];
    logic [NC_WIDTH-1:0] size_q [NUM_BARRIERS];
    logic [NC_WIDTH-1:0] size_d [NUM_BARRIERS];
    logic                rsp_valid_q, rsp_valid_d;
    logic [NB_WIDTH-1:0] rsp_id_q, rsp_id_d;
    logic                error_q, error_d;
    logic                dup, first, any_mask;
    logic [NC_WIDTH-1:0] eff_size;

    always_comb begin
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        error_d     = error_q;
        dup         = 1'b0;
        first       = 1'b0;
        eff_size    = '0;
        if (grant_valid) begin
            dup      = mask_q[acc.id][grant_idx];
            first    = (cnt_q[acc.id] == '0);
            eff_size = first ? acc.size_m1 : size_q[acc.id];
            if (acc.core_id != grant_idx) error_d = 1'b1;
            if (dup) begin
                error_d = 1'b1;
            end else begin
                // A disagreeing size is flagged, but the first arrival's size stays authoritative.
                if (!first && (acc.size_m1 != size_q[acc.id])) error_d = 1'b1;
                if (cnt_q[acc.id] == eff_size) begin
                    mask_d[acc.id] = '0;
                    cnt_d[acc.id]  = '0;
                    size_d[acc.id] = '0;
                    rsp_valid_d    = 1'b1;
                    rsp_id_d       = acc.id;
                end else begin
                    mask_d[acc.id][grant_idx] = 1'b1;
                    cnt_d[acc.id]             = cnt_q[acc.id] + NC_WIDTH'(1);
                    if (first) size_d[acc.id] = acc.size_m1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                mask_q[b] <= '0;
                cnt_q[b]  <= '0;
                size_q[b] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        any_mask = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++) any_mask = any_mask | (|mask_q[b]);
    end

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) rsp_data_o[i].id = rsp_id_q;
    end

    assign rsp_valid_o = {NUM_REQS{rsp_valid_q}};
    assign error       = error_q;
    assign busy        = any_mask | rsp_valid_q;

endmodule

// File: tb/tb_vx_gbar_collector.sv
// Randomized and directed bench for vx_gbar_collector against a set-based barrier model.
module tb_vx_gbar_collector;
    import vx_gbar_collector_pkg::*;

    localparam int NR = GBAR_NUM_CORES;
    localparam int NB = GBAR_NUM_BARRIERS;

    logic           clk = 1'b0;
    logic           reset;
    logic [NR-1:0]  req_valid_i;
    gbar_req_data_t req_data_i [NR];
    logic [NR-1:0]  req_ready_o;
    logic [NR-1:0]  rsp_valid_o;
    gbar_rsp_data_t rsp_data_o [NR];
    logic           error;
    logic           busy;

    vx_gbar_collector dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .error       (error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int n_rsp_seen = 0;
    logic [NB_WIDTH-1:0] exp_q[$];

    // Driver state: each port holds one request until it is granted.
    bit             pend  [NR];
    gbar_req_data_t pdata [NR];

    // Reference model: set of arrived cores and agreed participant count per barrier.
    bit [NR-1:0] m_who [NB];
    int          m_sz  [NB];
    int          m_ptr;
    bit          m_rsp_v;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < NB; b++) begin
            m_who[b] = '0;
            m_sz[b]  = 0;
        end
        m_ptr   = 0;
        m_rsp_v = 1'b0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    task automatic put(input int p, input int id, input int sz, input int cid);
        pend[p]          = 1'b1;
        pdata[p].id      = NB_WIDTH'(id);
        pdata[p].size_m1 = NC_WIDTH'(sz);
        pdata[p].core_id = NC_WIDTH'(cid);
    endtask

    task automatic step();
        int win, b, arrived, parts, q;
        bit any;
        logic [NB_WIDTH-1:0] e;
        @(negedge clk);
        for (int p = 0; p < NR; p++) begin
            req_valid_i[p] = pend[p];
            req_data_i[p]  = pdata[p];
        end
        #1;
        win = -1;
        for (int k = 0; k < NR; k++) begin
            q = (m_ptr + k) % NR;
            if (win < 0 && pend[q]) win = q;
        end
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("ready%0d", p), 32'(req_ready_o[p]), 32'(p == win));
            chk($sformatf("rsp_valid%0d", p), 32'(rsp_valid_o[p]), 32'(m_rsp_v));
        end
        if (rsp_valid_o[0]) begin
            n_rsp_seen++;
            chk("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < NR; p++) chk($sformatf("rsp_id%0d", p), 32'(rsp_data_o[p].id), 32'(e));
            end
        end
        any = m_rsp_v;
        for (int bb = 0; bb < NB; bb++) if (m_who[bb] != '0) any = 1'b1;
        chk("error", 32'(error), 32'(m_err));
        chk("busy", 32'(busy), 32'(any));

        m_rsp_v = 1'b0;
        if (win >= 0) begin
            b = int'(pdata[win].id);
            if (m_who[b][win]) begin
                m_err = 1'b1;
            end else begin
                arrived = $countones(m_who[b]);
                if (arrived == 0) begin
                    m_sz[b] = int'(pdata[win].size_m1);
                end else if (int'(pdata[win].size_m1) != m_sz[b]) begin
                    m_err = 1'b1;
                end
                parts = m_sz[b] + 1;
                if (arrived + 1 == parts) begin
                    m_who[b] = '0;
                    m_sz[b]  = 0;
                    m_rsp_v  = 1'b1;
                    exp_q.push_back(NB_WIDTH'(b));
                end else begin
                    m_who[b][win] = 1'b1;
                end
            end
            if (int'(pdata[win].core_id) != win) m_err = 1'b1;
            m_ptr = (win + 1) % NR;
            pend[win] = 1'b0;
        end
    endtask

    task automatic drain();
        bit any;
        for (int i = 0; i < 4 * NR; i++) begin
            any = 1'b0;
            for (int p = 0; p < NR; p++) if (pend[p]) any = 1'b1;
            if (any) step();
        end
        for (int p = 0; p < NR; p++) chk("drain_done", 32'(pend[p]), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < NR; p++) begin
            pend[p]        = 1'b0;
            req_valid_i[p] = 1'b0;
        end
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_id", 32'(rsp_data_o[0].id), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int base, id, sz, cid;
        reset       = 1'b1;
        req_valid_i = '0;
        for (int p = 0; p < NR; p++) begin
            pend[p]  = 1'b0;
            pdata[p] = '0;
            req_data_i[p] = '0;
        end
        model_clear();
        do_reset();

        // Staggered arrivals on barrier 2
        put(3, 2, 3, 3); step();
        put(1, 2, 3, 1); step();
        put(0, 2, 3, 0); step();
        put(2, 2, 3, 2); step();
        step(); step();

        // Simultaneous arrivals on barrier 0
        for (int p = 0; p < NR; p++) put(p, 0, 3, p);
        drain(); step(); step();

        // Single-participant barrier 5
        put(1, 5, 0, 1); step(); step(); step();

        // Interleaved independent barriers 1 and 3
        put(0, 1, 1, 0); step();
        put(2, 3, 1, 2); step();
        put(1, 1, 1, 1); step();
        put(3, 3, 1, 3); step();
        step(); step();
        chk("interleave_error", 32'(error), 32'd0);

        // Duplicate arrival on barrier 4
        put(2, 4, 2, 2); step();
        put(2, 4, 2, 2); step();
        put(0, 4, 2, 0); step();
        put(1, 4, 2, 1); step();
        step(); step();
        chk("dup_error_sticky", 32'(error), 32'd1);

        // Reset after partial arrivals discards them
        do_reset();
        put(0, 6, 3, 0); step();
        put(1, 6, 3, 1); step();
        do_reset();
        base = n_rsp_seen;
        put(2, 6, 3, 2); step();
        put(3, 6, 3, 3); step();
        step(); step();
        chk("no_release_after_reset", 32'(n_rsp_seen - base), 32'd0);
        chk("partial_busy", 32'(busy), 32'd1);

        // Randomized traffic with occasional protocol violations and resets
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc % 300 == 299) do_reset();
            for (int p = 0; p < NR; p++) begin
                if (!pend[p] && $urandom_range(0, 99) < 35) begin
                    id  = $urandom_range(0, NB - 1);
                    sz  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, NR - 1) : id % NR;
                    cid = ($urandom_range(0, 29) == 0) ? $urandom_range(0, NR - 1) : p;
                    put(p, id, sz, cid);
                end
            end
            step();
        end
        drain();
        step(); step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
